// File: rtl/opb_register_bank_simulink2ppc.sv
// OPB slave exposing C_NUM_CH user words as coherent snapshots, plus CTRL and STATUS words.
// Optional per-channel overflow flags when SNAP_OVERFLOW_EN is defined.
module opb_register_bank_simulink2ppc #(
    parameter logic [31:0] C_BASEADDR   = 32'h00000000,
    parameter logic [31:0] C_HIGHADDR   = 32'h000000FF,
    parameter int          C_OPB_AWIDTH = 32,
    parameter int          C_OPB_DWIDTH = 32,
    parameter int          C_NUM_CH     = 4,
    parameter int          C_USER_WIDTH = 32
) (
    input  logic                             OPB_Clk,
    input  logic                             OPB_Rst,
    input  logic [0:C_OPB_AWIDTH-1]          OPB_ABus,
    input  logic [0:C_OPB_DWIDTH/8-1]        OPB_BE,
    input  logic [0:C_OPB_DWIDTH-1]          OPB_DBus,
    input  logic                             OPB_RNW,
    input  logic                             OPB_select,
    input  logic                             OPB_seqAddr,
    output logic [0:C_OPB_DWIDTH-1]          Sl_DBus,
    output logic                             Sl_xferAck,
    output logic                             Sl_errAck,
    output logic                             Sl_retry,
    output logic                             Sl_toutSup,
    input  logic [C_NUM_CH*C_USER_WIDTH-1:0] user_data_in,
    input  logic [C_NUM_CH-1:0]              user_valid,
    input  logic                             user_snap
);
    localparam int WW = C_OPB_AWIDTH - 2;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ACK  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    logic [1:0]              state;
    logic [C_OPB_DWIDTH-1:0] rdata_q;
    logic [C_OPB_DWIDTH-1:0] rd_next;
    logic [C_OPB_DWIDTH-1:0] wdata;
    logic [C_OPB_DWIDTH-1:0] status;
    logic [C_OPB_AWIDTH-1:0] addr;
    logic [C_OPB_AWIDTH-1:0] off;
    logic [WW-1:0]           word;
    logic                    in_win;
    logic                    decode;
    logic                    wr_ctrl;
    logic                    snap_ev;
    logic                    auto_en;
    logic [15:0]             snap_cnt;
    logic [C_NUM_CH-1:0]     ovf;
    logic [C_USER_WIDTH-1:0] live   [C_NUM_CH];
    logic [C_USER_WIDTH-1:0] shadow [C_NUM_CH];
    logic                    unused_bits;

    // Bus is big-endian bit numbered; the internal vectors are little-endian.
    assign addr    = OPB_ABus;
    assign wdata   = OPB_DBus;
    assign off     = addr - C_OPB_AWIDTH'(C_BASEADDR);
    assign in_win  = (off <= C_OPB_AWIDTH'(C_HIGHADDR - C_BASEADDR));
    assign word    = off[C_OPB_AWIDTH-1:2];
    assign decode  = (state == ST_IDLE) && OPB_select && in_win;
    assign wr_ctrl = decode && !OPB_RNW && (word == WW'(C_NUM_CH)) && OPB_BE[C_OPB_DWIDTH/8-1];
    // AUTO pauses while a read is on the bus so the read sees a stable set.
    assign snap_ev = user_snap | (wr_ctrl & wdata[0]) | (auto_en & ~(OPB_select & OPB_RNW));

    assign Sl_errAck   = 1'b0;
    assign Sl_retry    = 1'b0;
    assign Sl_toutSup  = 1'b0;
    assign Sl_xferAck  = (state == ST_ACK);
    assign Sl_DBus     = (state == ST_ACK) ? rdata_q : '0;
    assign unused_bits = ^{1'b0, OPB_seqAddr, OPB_BE, wdata, off[1:0]};

    always_comb begin
        status = '0;
        status[15:0] = snap_cnt;
        status[16 +: C_NUM_CH] = ovf;
    end

    always_comb begin
        rd_next = '0;
        if (OPB_RNW) begin
            for (int i = 0; i < C_NUM_CH; i++)
                if (word == WW'(i)) rd_next[C_USER_WIDTH-1:0] = shadow[i];
            if (word == WW'(C_NUM_CH))     rd_next[1] = auto_en;
            if (word == WW'(C_NUM_CH + 1)) rd_next = status;
        end
    end

    always_ff @(posedge OPB_Clk) begin
        if (OPB_Rst) begin
            state    <= ST_IDLE;
            rdata_q  <= '0;
            auto_en  <= 1'b0;
            snap_cnt <= '0;
            for (int i = 0; i < C_NUM_CH; i++) begin
                live[i]   <= '0;
                shadow[i] <= '0;
            end
        end else begin
            case (state)
                ST_IDLE: if (decode) begin
                    state   <= ST_ACK;
                    rdata_q <= rd_next;
                end
                ST_ACK:  state <= OPB_select ? ST_HOLD : ST_IDLE;
                ST_HOLD: if (!OPB_select) state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
            if (wr_ctrl) auto_en <= wdata[1];
            if (snap_ev) snap_cnt <= snap_cnt + 16'd1;
            for (int i = 0; i < C_NUM_CH; i++) begin
                if (user_valid[i]) live[i] <= user_data_in[i*C_USER_WIDTH +: C_USER_WIDTH];
                if (snap_ev)       shadow[i] <= live[i];
            end
        end
    end

`ifdef SNAP_OVERFLOW_EN
    logic                clr_ovf;
    logic [C_NUM_CH-1:0] pend;

    assign clr_ovf = wr_ctrl & wdata[2];

    // pend marks a load not yet captured; a valid landing on the snapshot edge opens a new interval.
    always_ff @(posedge OPB_Clk) begin
        if (OPB_Rst) begin
            pend <= '0;
            ovf  <= '0;
        end else begin
            for (int i = 0; i < C_NUM_CH; i++) begin
                ovf[i]  <= (user_valid[i] & pend[i] & ~snap_ev) | (ovf[i] & ~clr_ovf);
                pend[i] <= user_valid[i] | (pend[i] & ~snap_ev);
            end
        end
    end
`else
    assign ovf = '0;
`endif

endmodule
